// File: rtl/reg_piso_tx_if.sv
// Load handshake and serial-side signals of the PISO transmitter.
// The master drives words in; the slave (the transmitter) drives the serial side.
interface reg_piso_tx_if #(
  parameter int NBITS_DATA = 4
);
  logic [NBITS_DATA-1:0] data_in;
  logic                  load_valid;
  logic                  load_ready;
  logic                  serial_out;
  logic                  serial_valid;
  logic                  last;
  logic                  done;

  modport master (
    output data_in, load_valid,
    input  load_ready, serial_out, serial_valid, last, done
  );

  modport slave (
    input  data_in, load_valid,
    output load_ready, serial_out, serial_valid, last, done
  );
endinterface

// File: rtl/reg_piso_tx.sv
// Parallel-in/serial-out transmitter: accepts a word on a valid/ready
// handshake and shifts it out LSB first, one bit per clock. A new word can
// be accepted during the final bit, so back-to-back words leave no gap.
module reg_piso_tx #(
  parameter int NBITS_DATA = 4
) (
  input  logic           clk,
  input  logic           reset,
  reg_piso_tx_if.slave   bus
);

  localparam int              CW       = $clog2(NBITS_DATA);
  localparam logic [CW-1:0]   LAST_CNT = CW'(NBITS_DATA - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state, state_next;
  logic [NBITS_DATA-1:0] shreg, shreg_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic                  done_q;

  logic at_last;
  logic fire;

  // The final bit of a word is being presented; this alone opens load_ready
  // while shifting, so no input reaches any output combinationally.
  assign at_last = (state == SHIFT) && (cnt == LAST_CNT);
  assign fire    = bus.load_valid && bus.load_ready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order the simulator runs processes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: shift register, bit counter and the registered done pulse.
  // NOTE: reset clears the shift register too, so a reset mid-word leaves no
  // stale bits that could leak out after deassertion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg  <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      shreg  <= shreg_next;
      cnt    <= cnt_next;
      done_q <= at_last;
    end
  end

  // Next-state and datapath update: load on handshake, otherwise shift right.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case
    // leaves it unassigned and infers a latch.
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;

    unique case (state)
      IDLE: begin
        if (fire) begin
          shreg_next = bus.data_in;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (at_last) begin
          if (fire) begin
            shreg_next = bus.data_in;
            cnt_next   = '0;
          end else begin
            shreg_next = '0;
            cnt_next   = '0;
            state_next = IDLE;
          end
        end else begin
          shreg_next = {1'b0, shreg[NBITS_DATA-1:1]};
          cnt_next   = cnt + CW'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only.
  assign bus.load_ready   = (state == IDLE) || at_last;
  assign bus.serial_valid = (state == SHIFT);
  assign bus.serial_out   = (state == SHIFT) && shreg[0];
  assign bus.last         = at_last;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_reg_piso_tx.sv
// Self-checking bench for reg_piso_tx: a 4-bit and an 8-bit instance, a
// queue-based transaction model compared every cycle, and directed
// per-cycle literal expectations for each scenario.
module tb_reg_piso_tx;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  reg_piso_tx_if #(.NBITS_DATA(4)) if4 ();
  reg_piso_tx_if #(.NBITS_DATA(8)) if8 ();

  reg_piso_tx #(.NBITS_DATA(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  reg_piso_tx #(.NBITS_DATA(8)) dut8 (.clk(clk), .reset(reset), .bus(if8));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Transaction model: the bits still to be sent, in send order.
  // A word is accepted when at most one bit remains (idle or final bit).
  bit q4[$];
  bit q8[$];
  bit done_m4 = 1'b0;
  bit done_m8 = 1'b0;
  bit fire4, fire8;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q4.delete();
      q8.delete();
      done_m4 = 1'b0;
      done_m8 = 1'b0;
    end else begin
      fire4   = if4.load_valid && (q4.size() <= 1);
      done_m4 = (q4.size() == 1);
      if (q4.size() > 0) void'(q4.pop_front());
      if (fire4) for (int i = 0; i < 4; i++) q4.push_back(if4.data_in[i]);

      fire8   = if8.load_valid && (q8.size() <= 1);
      done_m8 = (q8.size() == 1);
      if (q8.size() > 0) void'(q8.pop_front());
      if (fire8) for (int i = 0; i < 8; i++) q8.push_back(if8.data_in[i]);
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    check("m4.serial_valid", 32'(if4.serial_valid), 32'(q4.size() > 0));
    check("m4.serial_out",   32'(if4.serial_out),   32'((q4.size() > 0) ? q4[0] : 1'b0));
    check("m4.last",         32'(if4.last),         32'(q4.size() == 1));
    check("m4.load_ready",   32'(if4.load_ready),   32'(q4.size() <= 1));
    check("m4.done",         32'(if4.done),         32'(done_m4));
    check("m8.serial_valid", 32'(if8.serial_valid), 32'(q8.size() > 0));
    check("m8.serial_out",   32'(if8.serial_out),   32'((q8.size() > 0) ? q8[0] : 1'b0));
    check("m8.last",         32'(if8.last),         32'(q8.size() == 1));
    check("m8.load_ready",   32'(if8.load_ready),   32'(q8.size() <= 1));
    check("m8.done",         32'(if8.done),         32'(done_m8));
  end

  // Directed per-cycle expectations; bit i of each vector is cycle i+1.
  // Also rebuilds the word a SIPO register clocked on serial_valid would hold.
  task automatic expect_cycles(input string tag, input bit sel, input int n,
                               input logic [15:0] so, input logic [15:0] sv,
                               input logic [15:0] la, input logic [15:0] dn,
                               output logic [7:0] sipo);
    logic a_so, a_sv, a_la, a_dn;
    sipo = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a_so = sel ? if8.serial_out   : if4.serial_out;
      a_sv = sel ? if8.serial_valid : if4.serial_valid;
      a_la = sel ? if8.last         : if4.last;
      a_dn = sel ? if8.done         : if4.done;
      check($sformatf("%s.c%0d.serial_out",   tag, i + 1), 32'(a_so), 32'(so[i]));
      check($sformatf("%s.c%0d.serial_valid", tag, i + 1), 32'(a_sv), 32'(sv[i]));
      check($sformatf("%s.c%0d.last",         tag, i + 1), 32'(a_la), 32'(la[i]));
      check($sformatf("%s.c%0d.done",         tag, i + 1), 32'(a_dn), 32'(dn[i]));
      if (a_sv) begin
        if (sel) sipo = {a_so, sipo[7:1]};
        else     sipo[3:0] = {a_so, sipo[3:1]};
      end
    end
  endtask

  // Present a word for one clock edge starting from an idle instance.
  task automatic load(input bit sel, input logic [7:0] d);
    @(negedge clk);
    #1;
    if (sel) begin
      if8.data_in    = d;
      if8.load_valid = 1'b1;
    end else begin
      if4.data_in    = d[3:0];
      if4.load_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    if4.load_valid = 1'b0;
    if8.load_valid = 1'b0;
  endtask

  logic [7:0] sipo;

  initial begin
    if4.data_in    = '0;
    if4.load_valid = 1'b0;
    if8.data_in    = '0;
    if8.load_valid = 1'b0;

    // Reset held with a pending load: nothing may be captured or sent.
    #1;
    if4.data_in    = 4'b1111;
    if4.load_valid = 1'b1;
    if8.data_in    = 8'hFF;
    if8.load_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst.serial_valid", 32'(if4.serial_valid), 32'd0);
      check("rst.load_ready",   32'(if4.load_ready),   32'd1);
      check("rst.serial_out",   32'(if4.serial_out),   32'd0);
      check("rst.done",         32'(if4.done),         32'd0);
    end
    #1;
    if4.load_valid = 1'b0;
    if8.load_valid = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    expect_cycles("idle", 1'b0, 2, 16'h0, 16'h0, 16'h0, 16'h0, sipo);

    // Single word 1011: bits 1,1,0,1 then done.
    load(1'b0, 8'h0B);
    expect_cycles("single", 1'b0, 5, 16'b01011, 16'b01111, 16'b01000, 16'b10000, sipo);
    check("single.sipo", 32'(sipo[3:0]), 32'h0000000B);

    // Back-to-back: 0110 offered during the last bit of 1011.
    load(1'b0, 8'h0B);
    fork
      expect_cycles("b2b", 1'b0, 9, 16'b001101011, 16'b011111111,
                    16'b010001000, 16'b100010000, sipo);
      begin
        repeat (3) @(posedge clk);
        #1;
        if4.data_in    = 4'b0110;
        if4.load_valid = 1'b1;
        @(posedge clk);
        #1;
        if4.load_valid = 1'b0;
      end
    join
    check("b2b.sipo", 32'(sipo[3:0]), 32'h00000006);

    // Load attempted while busy (cycles 1-3) is ignored.
    load(1'b0, 8'h0F);
    fork
      expect_cycles("busy", 1'b0, 5, 16'b01111, 16'b01111, 16'b01000, 16'b10000, sipo);
      begin
        if4.data_in    = 4'b0000;
        if4.load_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if4.load_valid = 1'b0;
      end
    join
    check("busy.sipo", 32'(sipo[3:0]), 32'h0000000F);

    // Reset asserted between edges during bit 2 of 1010.
    load(1'b0, 8'h0A);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst.serial_valid", 32'(if4.serial_valid), 32'd0);
    check("midrst.serial_out",   32'(if4.serial_out),   32'd0);
    check("midrst.load_ready",   32'(if4.load_ready),   32'd1);
    @(negedge clk);
    check("midrst.done", 32'(if4.done), 32'd0);
    #1;
    reset = 1'b1;
    expect_cycles("postrst", 1'b0, 3, 16'h0, 16'h0, 16'h0, 16'h0, sipo);
    load(1'b0, 8'h01);
    expect_cycles("after", 1'b0, 5, 16'b00001, 16'b01111, 16'b01000, 16'b10000, sipo);
    check("after.sipo", 32'(sipo[3:0]), 32'h00000001);

    // 8-bit instance: A5 goes out as 1,0,1,0,0,1,0,1.
    load(1'b1, 8'hA5);
    expect_cycles("w8", 1'b1, 9, 16'h0A5, 16'h0FF, 16'h080, 16'h100, sipo);
    check("w8.sipo", 32'(sipo), 32'h000000A5);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_piso_tx.md
# reg_piso_tx

Parallel-in/serial-out transmitter register. It accepts an NBITS_DATA-bit word through a valid/ready load handshake and shifts it out one bit per clock, LSB first. The bit order matches the team's serial-in/parallel-out shift register, which inserts new bits at the MSB and shifts toward bit 0. When that register is clocked only on cycles where `serial_valid` = 1, it holds the original word after NBITS_DATA bits. The block is the transmit end of the serial data path between register-file blocks.

## Interface

**Parameters**
- `NBITS_DATA`, default 4: word width. Legal range is ≥ 2.

**Ports**
- `clk` input, 1 bit: single clock. All state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low. Assertion clears all state immediately. Deassertion is synchronous to `clk` externally.
- `data_in` input, NBITS_DATA bits: parallel word to transmit. Sampled only on handshake.
- `load_valid` input, 1 bit: `data_in` holds a word to send.
- `load_ready` output, 1 bit: block can accept a word this cycle.
- `serial_out` output, 1 bit: current serial bit.
- `serial_valid` output, 1 bit: `serial_out` carries a data bit this cycle.
- `last` output, 1 bit: current bit is the final bit (MSB) of the word.
- `done` output, 1 bit: one-cycle pulse in the cycle after the last bit.

## Operation

**Reset values** (while `reset` = 0): FSM = IDLE, shift register = 0, bit counter = 0. All outputs are 0 except `load_ready`, which is 1.

**FSM states**
- **IDLE**
  - `load_ready` = 1, `serial_valid` = 0, `serial_out` = 0.
  - On `load_valid` & `load_ready`: capture `data_in` into the shift register, clear the counter, go to SHIFT.
- **SHIFT**
  - `serial_out` = shreg[0] and `serial_valid` = 1.
  - Each clock, shift the register right by 1 (zero fill at MSB) and increment the counter.
  - `last` = 1 when counter = NBITS_DATA-1.
  - `load_ready` = 1 only when counter = NBITS_DATA-1.
  - Exit from the final bit:
    - If `load_valid` is high in that cycle, load the new word, clear the counter and stay in SHIFT (back-to-back words with no gap).
    - Otherwise go to IDLE.

**Other rules**
- The counter width is ceil(log2(NBITS_DATA)) bits. It never wraps inside a word; it is cleared on every load.
- `done` is registered. It is 1 in the cycle after any final bit, including back-to-back transfers, where it coincides with bit 0 of the next word.
- `load_valid` while `load_ready` = 0 is ignored. No word is captured and `data_in` may change freely.
- Reset mid-word aborts the transfer immediately. No partial bits are sent after deassertion, and no `done` pulse is produced.

## Timing

- **Load latency:** handshake at edge N puts bit 0 on `serial_out` from edge N until edge N+1 (cycle N+1). Bit k appears in cycle N+1+k.
- **Word duration:** NBITS_DATA cycles of `serial_valid`. `done` appears in cycle N+1+NBITS_DATA.
- **Throughput:** 1 bit/clock sustained with back-to-back loads. Minimum gap between words is 0 cycles.
- **Output timing:** all outputs are registered or decoded from registered state only. No combinational path from `load_valid` or `data_in` to any output.

## Test plan

- **Reset:** hold `reset` = 0, apply `load_valid` = 1 and `data_in` = 4'b1111.
  - Required: `serial_valid` = 0, `load_ready` = 1, `serial_out` = 0 throughout, and nothing loaded.
- **Single word:** load 4'b1011.
  - Required: `serial_out` = 1,1,0,1 in cycles 1–4, `serial_valid` = 1 in those cycles, `last` in cycle 4, `done` in cycle 5.
  - A shift register clocked on `serial_valid` then reads 4'b1011.
- **Back-to-back:** load 4'b1011, then hold `load_valid` with 4'b0110 during `last`.
  - Required: `serial_out` = 1,1,0,1,0,1,1,0 with no gap, `done` coincident with the first bit of the second word, and a second `done` after it.
- **Load while busy:** `load_valid` with 4'b0000 asserted in cycles 1–3 of a 4'b1111 transfer.
  - Required: ignored. Output is 1,1,1,1, then IDLE.
- **Reset mid-word:** assert `reset` asynchronously (between edges) during bit 2 of 4'b1010.
  - Required: `serial_valid` and `serial_out` go to 0 immediately, with no `done`.
  - After release, a new load of 4'b0001 sends 1,0,0,0.
- **Parameter sweep:** NBITS_DATA = 8, load 8'hA5.
  - Required: `serial_out` = 1,0,1,0,0,1,0,1 over 8 cycles, `last` on the 8th, `done` on the 9th.
